// File: rtl/dot_product_engine.sv
// Sequential signed-weight x unsigned-activation dot product with ReLU/saturate output.
// Operands are snapshotted on start; one element is accumulated per clock.
module dot_product_engine #(
  parameter int N_ELEM = 16,
  parameter int W_BITS = 2,
  parameter int D_BITS = 8,
  parameter int ACC_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_ELEM*W_BITS-1:0] weights,
  input  logic [N_ELEM*D_BITS-1:0] data,
  output logic                     busy,
  output logic                     done,
  output logic [ACC_W-1:0]         result,
  output logic [D_BITS-1:0]        act_out
);

  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int P_W   = W_BITS + D_BITS + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << D_BITS) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic [1:0] {IDLE, ACC, FINISH} state_t;

  state_t state, state_nxt;

  logic [N_ELEM*W_BITS-1:0] w_sh;
  logic [N_ELEM*D_BITS-1:0] d_sh;
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         idx;

  logic signed [W_BITS-1:0] w_elem;
  logic signed [D_BITS:0]   d_elem;
  logic signed [P_W-1:0]    prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [D_BITS-1:0]        act_sat;

  // Activation gets a zero MSB so the signed multiply treats it as unsigned.
  assign w_elem   = w_sh[W_BITS*idx +: W_BITS];
  assign d_elem   = {1'b0, d_sh[D_BITS*idx +: D_BITS]};
  assign prod     = w_elem * d_elem;
  assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};

  always_comb begin
    act_sat = acc[D_BITS-1:0];
    if (acc[ACC_W-1]) begin
      act_sat = '0;
    end else if (acc > SAT_MAX) begin
      act_sat = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACC;
      ACC:     if (idx == LAST_IDX) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_sh    <= '0;
      d_sh    <= '0;
      acc     <= '0;
      idx     <= '0;
      done    <= 1'b0;
      result  <= '0;
      act_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w_sh <= weights;
            d_sh <= data;
            acc  <= '0;
            idx  <= '0;
          end
        end
        ACC: begin
          acc <= acc + prod_ext;
          idx <= idx + IDX_W'(1);
        end
        FINISH: begin
          result  <= acc;
          act_out <= act_sat;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench for dot_product_engine: directed corner cases plus random
// vectors compared against an arithmetic dot-product model.
module tb_dot_product_engine;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [31:0]  weights;
  logic [127:0] data;
  logic         busy;
  logic         done;
  logic [15:0]  result;
  logic [7:0]   act_out;

  int nChecks;
  int nMiscompares;

  dot_product_engine dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .weights (weights),
    .data    (data),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .act_out (act_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer sum of signed weight times unsigned activation.
  function automatic int refDot(input logic [31:0] w, input logic [127:0] d);
    int sum;
    int wi;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      wi = int'(w[2*i +: 2]);
      if (wi > 1) wi = wi - 4;
      sum = sum + wi * int'(d[8*i +: 8]);
    end
    return sum;
  endfunction

  function automatic int refAct(input int sum);
    if (sum < 0) return 0;
    if (sum > 255) return 255;
    return sum;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w, input logic [127:0] d, input logic s);
    @(negedge clk);
    weights = w;
    data    = d;
    start   = s;
  endtask

  // One start pulse; optionally a stray start with new operands at E5.
  task automatic runVector(input string tag, input logic [31:0] w, input logic [127:0] d, input bit midStart);
    int expSum;
    int lat;
    int busyCnt;
    int extraDone;
    expSum = refDot(w, d);
    applyStimulus(w, d, 1'b1);
    @(posedge clk);
    lat = 99;
    busyCnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (midStart && k == 4) begin
        weights = 32'hFFFF_FFFF;
        data    = ~d;
        start   = 1'b1;
      end
      if (midStart && k == 5) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busyCnt++;
    end
    checkOutput({tag, "_latency"}, lat, 17);
    checkOutput({tag, "_busy_cycles"}, busyCnt, 17);
    checkOutput({tag, "_busy_at_done"}, {31'b0, busy}, 0);
    checkOutput({tag, "_result"}, {16'b0, result}, {16'b0, expSum[15:0]});
    checkOutput({tag, "_act_out"}, {24'b0, act_out}, refAct(expSum));
    extraDone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) extraDone++;
    end
    checkOutput({tag, "_extra_done"}, extraDone, 0);
    checkOutput({tag, "_result_hold"}, {16'b0, result}, {16'b0, expSum[15:0]});
  endtask

  initial begin
    int expSum;
    int doneCnt;
    int doneAt[2];
    logic [31:0] rw;
    logic [127:0] rd;

    nChecks      = 0;
    nMiscompares = 0;
    rst_n   = 1'b1;
    start   = 1'b0;
    weights = '0;
    data    = '0;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_busy", {31'b0, busy}, 0);
    checkOutput("reset_done", {31'b0, done}, 0);
    checkOutput("reset_result", {16'b0, result}, 0);
    checkOutput("reset_act", {24'b0, act_out}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runVector("zeros", 32'h0, 128'h0, 1'b0);
    runVector("all_plus1", 32'h5555_5555, {16{8'hFF}}, 1'b0);
    runVector("all_minus2", 32'hAAAA_AAAA, {16{8'hFF}}, 1'b0);
    runVector("mid_start", 32'h0000_0001, 128'h2A, 1'b1);

    // Start held high: back-to-back results every 18 cycles.
    expSum = refDot(32'h3, 128'h10);
    applyStimulus(32'h3, 128'h10, 1'b1);
    @(posedge clk);
    doneCnt = 0;
    doneAt[0] = 99;
    doneAt[1] = 99;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) begin
        doneAt[doneCnt] = k;
        checkOutput($sformatf("held_result%0d", doneCnt), {16'b0, result}, {16'b0, expSum[15:0]});
        checkOutput($sformatf("held_act%0d", doneCnt), {24'b0, act_out}, refAct(expSum));
        doneCnt++;
        if (doneCnt == 2) begin
          start = 1'b0;
          break;
        end
      end
    end
    checkOutput("held_first_done", doneAt[0], 17);
    checkOutput("held_second_done", doneAt[1], 35);
    repeat (20) @(negedge clk);

    // Asynchronous reset in the middle of an accumulation.
    applyStimulus(32'h5555_5555, {16{8'h80}}, 1'b1);
    @(posedge clk);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'b0, busy}, 0);
    checkOutput("midrst_done", {31'b0, done}, 0);
    checkOutput("midrst_result", {16'b0, result}, 0);
    checkOutput("midrst_act", {24'b0, act_out}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("midrst_no_done", doneCnt, 0);
    checkOutput("midrst_result_hold", {16'b0, result}, 0);
    runVector("after_reset", 32'h0000_0009, {8'h00, 8'h77, {13{8'h00}}, 8'h33}, 1'b0);

    for (int n = 0; n < 24; n++) begin
      rw = $urandom();
      if (n % 3 == 1) rw = rw & 32'h5555_5555;
      if (n % 3 == 2) rw = rw & $urandom();
      rd = {$urandom(), $urandom(), $urandom(), $urandom()};
      runVector($sformatf("rand%0d", n), rw, rd, bit'(n % 4 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiscompares);
    $finish;
  end

endmodule
